// File: rtl/uart_pkg.sv
// Shared UART constants and the command-assembler state type.
package uart_pkg;

  // Clock cycles per serial bit and per 10-bit character.
  localparam int unsigned BAUD_DIV    = 2604;
  localparam int unsigned CHAR_CYCLES = 10 * BAUD_DIV;

  // Default inter-byte timeout: four character times.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4 * CHAR_CYCLES;

  typedef enum logic [0:0] {
    IDLE,
    COLLECT
  } asm_state_t;

endpackage

// File: rtl/uart_cmd_assembler.sv
// Packs NUM_BYTES received UART bytes (first byte most significant) into one
// command word with a cmd_rdy / clr_cmd_rdy handshake. A partial command is
// dropped when the gap between bytes reaches TIMEOUT_CYCLES.
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_rdy,
  output logic                   rx_rdy_clr,
  input  logic                   clr_cmd_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  output logic                   overrun
);

  localparam int unsigned CmdW = 8 * NUM_BYTES;
  localparam int unsigned ShW  = 8 * (NUM_BYTES - 1);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned IdxW = $clog2(NUM_BYTES + 1);

  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_BYTES - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  asm_state_t      state_q;
  logic [IdxW-1:0] idx_q;
  logic [CntW-1:0] cnt_q;
  logic [ShW-1:0]  shift_q;

  logic            accept;
  logic            complete;
  logic            timed_out;
  logic [CmdW-1:0] shift_ext;

  // A byte is taken only while no clear is in flight, so a level rx_rdy that
  // drops one cycle after the clear is never captured twice.
  assign accept    = rx_rdy & ~rx_rdy_clr;
  assign shift_ext = {shift_q, rx_data};
  assign complete  = accept && (state_q == COLLECT) && (idx_q == IdxLast);
  // An arriving byte takes priority over the timeout.
  assign timed_out = !accept && (state_q == COLLECT) && (cnt_q == CntLast);

  // Byte handshake, collection FSM and the registered command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_rdy_clr <= 1'b0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_rdy_clr <= accept;

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (accept) begin
            shift_q <= shift_ext[ShW-1:0];
            idx_q   <= IdxOne;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            shift_q <= shift_ext[ShW-1:0];
            cnt_q   <= '0;
            if (complete) begin
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + IdxOne;
            end
          end else if (timed_out) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          cnt_q   <= '0;
        end
      endcase

      // Completion has priority over the consumer's clear.
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
        overrun <= 1'b0;
      end
      if (complete) begin
        cmd     <= shift_ext;
        cmd_rdy <= 1'b1;
        if (cmd_rdy && !clr_cmd_rdy) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler with a shortened inter-byte timeout.
module tb_uart_cmd_assembler;

  localparam int unsigned NB = 3;
  localparam int unsigned TO = 64;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_rdy;
  logic          rx_rdy_clr;
  logic          clr_cmd_rdy;
  logic [23:0]   cmd;
  logic          cmd_rdy;
  logic          overrun;

  int n_vec;
  int n_err;

  uart_cmd_assembler #(
    .NUM_BYTES     (NB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .rx_rdy_clr (rx_rdy_clr),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one byte and hold rx_rdy until the clear is seen; returns at the
  // sample just after the capturing edge.
  task automatic send_byte(input logic [7:0] b);
    bit seen;
    seen    = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (rx_rdy_clr) seen = 1'b1;
    end
    rx_rdy = 1'b0;
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL send_byte: no rx_rdy_clr for byte %02h (got 0, want 1)", b);
    end
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec += 4;
    if (rx_rdy_clr !== 1'b0) begin n_err++; $display("FAIL reset rx_rdy_clr got %b want 0", rx_rdy_clr); end
    if (cmd !== 24'h0) begin n_err++; $display("FAIL reset cmd got %06h want 000000", cmd); end
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL reset cmd_rdy got %b want 0", cmd_rdy); end
    if (overrun !== 1'b0) begin n_err++; $display("FAIL reset overrun got %b want 0", overrun); end
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_basic();
    send_byte(8'hA5);
    idle_cycle();
    n_vec++;
    if (rx_rdy_clr !== 1'b0) begin n_err++; $display("FAIL basic clr_width got %b want 0", rx_rdy_clr); end
    send_byte(8'h3C);
    n_vec++;
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL basic early_rdy got %b want 0", cmd_rdy); end
    send_byte(8'h7E);
    n_vec += 3;
    if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL basic cmd_rdy got %b want 1", cmd_rdy); end
    if (cmd !== 24'hA53C7E) begin n_err++; $display("FAIL basic cmd got %06h want a53c7e", cmd); end
    if (overrun !== 1'b0) begin n_err++; $display("FAIL basic overrun got %b want 0", overrun); end
    pulse_clr();
  endtask

  // rx_rdy stays high the cycle the clear is out, as UART_rcv does.
  task automatic test_hold();
    idle_cycle();
    rx_data = 8'h11;
    rx_rdy  = 1'b1;
    idle_cycle();
    idle_cycle();
    rx_rdy = 1'b0;
    n_vec++;
    if (rx_rdy_clr !== 1'b0) begin n_err++; $display("FAIL hold double_capture clr got %b want 0", rx_rdy_clr); end
    send_byte(8'h22);
    send_byte(8'h33);
    n_vec += 2;
    if (cmd !== 24'h112233) begin n_err++; $display("FAIL hold cmd got %06h want 112233", cmd); end
    if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL hold cmd_rdy got %b want 1", cmd_rdy); end
    pulse_clr();
  endtask

  // rx_rdy held high continuously: one byte every two cycles.
  task automatic test_rate();
    logic [7:0] seq [3];
    int         k;
    int         pulses;
    seq[0] = 8'h44; seq[1] = 8'h55; seq[2] = 8'h66;
    k = 0;
    pulses = 0;
    idle_cycle();
    rx_data = seq[0];
    rx_rdy  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      idle_cycle();
      if (rx_rdy_clr) begin
        pulses++;
        k++;
        if (k < 3) rx_data = seq[k];
      end
    end
    rx_rdy = 1'b0;
    n_vec += 3;
    if (pulses !== 3) begin n_err++; $display("FAIL rate pulses got %0d want 3", pulses); end
    if (cmd !== 24'h445566) begin n_err++; $display("FAIL rate cmd got %06h want 445566", cmd); end
    if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rate cmd_rdy got %b want 1", cmd_rdy); end
    pulse_clr();
  endtask

  // Byte arriving on the very edge the timeout would fire still counts.
  task automatic test_timeout_tie();
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (TO - 1) @(posedge clk);
    #1;
    send_byte(8'h03);
    n_vec += 2;
    if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL tie cmd_rdy got %b want 1", cmd_rdy); end
    if (cmd !== 24'h010203) begin n_err++; $display("FAIL tie cmd got %06h want 010203", cmd); end
    pulse_clr();
  endtask

  // Byte one edge after the timeout starts a fresh command.
  task automatic test_timeout();
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (TO) @(posedge clk);
    #1;
    send_byte(8'hAA);
    n_vec += 2;
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL timeout stale_rdy got %b want 0", cmd_rdy); end
    if (cmd !== 24'h010203) begin n_err++; $display("FAIL timeout cmd_kept got %06h want 010203", cmd); end
    send_byte(8'hBB);
    n_vec++;
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL timeout early_rdy got %b want 0", cmd_rdy); end
    send_byte(8'hCC);
    n_vec += 2;
    if (cmd !== 24'hAABBCC) begin n_err++; $display("FAIL timeout cmd got %06h want aabbcc", cmd); end
    if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL timeout cmd_rdy got %b want 1", cmd_rdy); end
    pulse_clr();
  endtask

  task automatic test_overrun();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    n_vec++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr first got %b want 0", overrun); end
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    n_vec += 3;
    if (cmd !== 24'h000002) begin n_err++; $display("FAIL ovr cmd got %06h want 000002", cmd); end
    if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL ovr cmd_rdy got %b want 1", cmd_rdy); end
    if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr flag got %b want 1", overrun); end
    pulse_clr();
    n_vec += 3;
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL ovr clr_rdy got %b want 0", cmd_rdy); end
    if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr clr_flag got %b want 0", overrun); end
    if (cmd !== 24'h000002) begin n_err++; $display("FAIL ovr cmd_hold got %06h want 000002", cmd); end
  endtask

  // clr_cmd_rdy on the completing edge while a command is still pending.
  task automatic test_back_to_back();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h33);
    send_byte(8'h44);
    idle_cycle();
    rx_data     = 8'h55;
    rx_rdy      = 1'b1;
    clr_cmd_rdy = 1'b1;
    idle_cycle();
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    n_vec += 4;
    if (rx_rdy_clr !== 1'b1) begin n_err++; $display("FAIL b2b capture got %b want 1", rx_rdy_clr); end
    if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL b2b cmd_rdy got %b want 1", cmd_rdy); end
    if (cmd !== 24'h334455) begin n_err++; $display("FAIL b2b cmd got %06h want 334455", cmd); end
    if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b overrun got %b want 0", overrun); end
  endtask

  // Reset mid-command: outputs clear asynchronously and the partial is lost.
  task automatic test_reset_mid();
    send_byte(8'h12);
    send_byte(8'h34);
    rst_n = 1'b0;
    #1;
    n_vec += 4;
    if (rx_rdy_clr !== 1'b0) begin n_err++; $display("FAIL rstmid rx_rdy_clr got %b want 0", rx_rdy_clr); end
    if (cmd !== 24'h0) begin n_err++; $display("FAIL rstmid cmd got %06h want 000000", cmd); end
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL rstmid cmd_rdy got %b want 0", cmd_rdy); end
    if (overrun !== 1'b0) begin n_err++; $display("FAIL rstmid overrun got %b want 0", overrun); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycle();
    send_byte(8'hDE);
    n_vec++;
    if (cmd_rdy !== 1'b0) begin n_err++; $display("FAIL rstmid stale_partial got %b want 0", cmd_rdy); end
    send_byte(8'hAD);
    send_byte(8'hBE);
    n_vec += 2;
    if (cmd !== 24'hDEADBE) begin n_err++; $display("FAIL rstmid cmd_after got %06h want deadbe", cmd); end
    if (cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rstmid cmd_rdy_after got %b want 1", cmd_rdy); end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    rx_data     = 8'h00;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_rate();
    test_timeout_tie();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
